d_cache_tag_array: RTL and testbench
====================================

# d_cache_tag_array

Parametrised, set-associative tag store for the L1 data cache, replacing the single-way 64-entry tag RAM. It holds a tag, valid bit and dirty bit per way per set, compares all ways in parallel, and returns a registered hit/miss result with a victim choice one cycle after a lookup. It also clears all valid bits with a set-by-set sweep after reset or on a flush request, and sits between the D-cache control FSM and the data array.

## Interface
- `WAYS`, default 2: associativity; power of two, ≥2.
- `SETS`, default 64: number of sets; power of two, ≥2.
- `TAG_W`, default 52: tag width in bits.
- `IW` (local), = log2(SETS); `WW` (local), = log2(WAYS).

- `clk` input 1: the only clock.
- `rst` input 1: synchronous, active-high reset.
- `lookup_valid_i` input 1: lookup request this cycle.
- `lookup_index_i` input IW: set index of the lookup.
- `lookup_tag_i` input TAG_W: tag to compare.
- `rsp_valid_o` output 1: lookup result valid (one-cycle pulse).
- `hit_o` output 1: some valid way matched.
- `hit_way_o` output WW: matching way, 0 on miss.
- `hit_dirty_o` output 1: dirty bit of the hit way.
- `victim_way_o` output WW: way to refill on a miss.
- `victim_valid_o` output 1: victim way currently holds a valid line.
- `victim_dirty_o` output 1: victim line needs writeback.
- `victim_tag_o` output TAG_W: victim tag, used for the writeback address.
- `wr_ena_i` input 1: fill write; sets valid=1.
- `wr_index_i` input IW, `wr_way_i` input WW, `wr_tag_i` input TAG_W, `wr_dirty_i` input 1: fill contents.
- `mark_dirty_i` input 1: set dirty on (`wr_index_i`, `wr_way_i`) without changing the tag.
- `flush_i` input 1: start an invalidate-all sweep.
- `busy_o` output 1: sweep in progress; lookups and writes are ignored.

## Operation
- Storage per set/way: tag[TAG_W], valid, dirty. Per set: round-robin pointer rr[WW].
- FSM states:
  - SWEEP: clears set `sweep_cnt` each cycle (valid=0, dirty=0, rr=0), then increments `sweep_cnt`. Goes to IDLE after clearing set SETS-1.
  - IDLE: serves lookups and writes.
- Entering SWEEP:
  - `rst` forces SWEEP with `sweep_cnt`=0.
  - `flush_i` in IDLE enters SWEEP next cycle with `sweep_cnt`=0.
  - `flush_i` while in SWEEP is ignored; the sweep does not restart.
- Lookup (IDLE, `lookup_valid_i`=1):
  - hit = valid & tag equal, checked for every way. More than one matching way is illegal; if it happens, `hit_way_o` reports the lowest index.
  - Victim is the lowest-index invalid way. If no way is invalid, the victim is rr[index].
- Write (IDLE):
  - `wr_ena_i`: tag←`wr_tag_i`, valid←1, dirty←`wr_dirty_i`. If `wr_way_i`==rr[index], rr[index] advances by 1 modulo WAYS.
  - `mark_dirty_i` with `wr_ena_i`=0: dirty←1 only if valid=1.
  - `wr_ena_i` and `mark_dirty_i` together: `wr_ena_i` wins, and dirty←`wr_dirty_i`|1.
- Lookup and write in the same cycle, same set: the lookup sees the pre-write contents (read-before-write).
- `lookup_valid_i`, `wr_ena_i` and `mark_dirty_i` in SWEEP: dropped. `rsp_valid_o` stays 0. The requester must hold until `busy_o`=0.

## Timing
- Reset values while `rst`=1: `busy_o`=1; `rsp_valid_o`, `hit_o`, `hit_way_o`, `hit_dirty_o`, `victim_*` all 0.
- Sweep after `rst` falls at edge E: sets 0..SETS-1 are cleared on edges E..E+SETS-1, and `busy_o`=0 from E+SETS.
- Flush latency: `flush_i` sampled at edge F → `busy_o`=1 after F, and `busy_o`=0 after F+SETS.
- Reset in mid-sweep: the sweep restarts at set 0.
- Lookup latency: 1 cycle. A lookup sampled at edge N drives all result outputs, registered, after N.
  - Outputs hold their values until the next accepted lookup.
  - `rsp_valid_o` is high only in the cycle after N.
- Throughput: one lookup per cycle; back-to-back lookups are supported.
- Writes take effect at the sampling edge. A lookup at N+1 to the same set sees a write made at N.

## Test plan
- Reset sweep: hold `rst` 3 cycles, release → `busy_o`=1 for exactly 64 cycles. A lookup at set 5, tag 0x123, issued in the first idle cycle → `rsp_valid_o`=1, `hit_o`=0, `victim_way_o`=0, `victim_valid_o`=0.
- Fill and hit: write set 7, way 1, tag 0xABC, dirty 0; lookup set 7, tag 0xABC → `hit_o`=1, `hit_way_o`=1, `hit_dirty_o`=0. Then `mark_dirty_i` on set 7, way 1, and look up again → `hit_dirty_o`=1.
- Replacement: fill set 3, ways 0 and 1, with tags 0x10 (dirty) and 0x11. Lookup tag 0x12 → `victim_way_o`=0, `victim_tag_o`=0x10, `victim_dirty_o`=1. Refill way 0, look up again → `victim_way_o`=1.
- Read-before-write: in one cycle, lookup set 9, tag 0x55 and write set 9, way 0, tag 0x55 → miss. Repeat the lookup next cycle → hit on way 0.
- Flush: with lines valid, pulse `flush_i` → `busy_o`=1 for 64 cycles. A lookup during the sweep gives `rsp_valid_o`=0. After the sweep, all prior tags miss and `victim_dirty_o`=0.
- Parameters: WAYS=4, SETS=16 → the sweep lasts 16 cycles. Four fills into set 2 give valid victims that rotate 0,1,2,3.

Source files
------------

// File: rtl/d_cache_tag_array.sv
// Set-associative tag store for the L1 D-cache: parallel tag compare, registered
// hit/victim result one cycle after a lookup, and a set-by-set invalidate sweep.
module d_cache_tag_array #(
    parameter int WAYS  = 2,
    parameter int SETS  = 64,
    parameter int TAG_W = 52
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     lookup_valid_i,
    input  logic [$clog2(SETS)-1:0]  lookup_index_i,
    input  logic [TAG_W-1:0]         lookup_tag_i,
    output logic                     rsp_valid_o,
    output logic                     hit_o,
    output logic [$clog2(WAYS)-1:0]  hit_way_o,
    output logic                     hit_dirty_o,
    output logic [$clog2(WAYS)-1:0]  victim_way_o,
    output logic                     victim_valid_o,
    output logic                     victim_dirty_o,
    output logic [TAG_W-1:0]         victim_tag_o,
    input  logic                     wr_ena_i,
    input  logic [$clog2(SETS)-1:0]  wr_index_i,
    input  logic [$clog2(WAYS)-1:0]  wr_way_i,
    input  logic [TAG_W-1:0]         wr_tag_i,
    input  logic                     wr_dirty_i,
    input  logic                     mark_dirty_i,
    input  logic                     flush_i,
    output logic                     busy_o
);
    localparam int IW = $clog2(SETS);
    localparam int WW = $clog2(WAYS);

    typedef enum logic {ST_SWEEP, ST_IDLE} state_e;

    state_e            state_q, state_d;
    logic [IW-1:0]     sweep_cnt_q, sweep_cnt_d;

    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   dirty_q [SETS];
    logic [WW-1:0]     rr_q    [SETS];

    logic              idle;
    logic              lookup_acc;

    logic              hit_d;
    logic [WW-1:0]     hit_way_d;
    logic              hit_dirty_d;
    logic [WW-1:0]     victim_way_d;
    logic              victim_valid_d;
    logic              victim_dirty_d;
    logic [TAG_W-1:0]  victim_tag_d;

    logic              rsp_valid_q;
    logic              hit_q;
    logic [WW-1:0]     hit_way_q;
    logic              hit_dirty_q;
    logic [WW-1:0]     victim_way_q;
    logic              victim_valid_q;
    logic              victim_dirty_q;
    logic [TAG_W-1:0]  victim_tag_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_SWEEP;
            sweep_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            sweep_cnt_q <= sweep_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sweep_cnt_d = sweep_cnt_q;
        busy_o      = 1'b0;
        case (state_q)
            ST_SWEEP: begin
                busy_o      = 1'b1;
                sweep_cnt_d = sweep_cnt_q + 1'b1;
                if (sweep_cnt_q == IW'(SETS - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (flush_i) begin
                    state_d     = ST_SWEEP;
                    sweep_cnt_d = '0;
                end
            end
            default: begin
                state_d = ST_SWEEP;
            end
        endcase
    end

    assign idle       = (state_q == ST_IDLE) && !rst;
    assign lookup_acc = idle && lookup_valid_i;

    // Descending scans so the lowest-index way wins both for hit and for invalid victim.
    always_comb begin
        hit_d        = 1'b0;
        hit_way_d    = '0;
        hit_dirty_d  = 1'b0;
        victim_way_d = rr_q[lookup_index_i];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[lookup_index_i][w] && (tag_q[lookup_index_i][w] == lookup_tag_i)) begin
                hit_d       = 1'b1;
                hit_way_d   = WW'(w);
                hit_dirty_d = dirty_q[lookup_index_i][w];
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[lookup_index_i][w]) begin
                victim_way_d = WW'(w);
            end
        end
        victim_valid_d = valid_q[lookup_index_i][victim_way_d];
        victim_dirty_d = victim_valid_d & dirty_q[lookup_index_i][victim_way_d];
        victim_tag_d   = tag_q[lookup_index_i][victim_way_d];
    end

    // Storage: the sweep owns the arrays while busy; fills beat mark-dirty.
    always_ff @(posedge clk) begin
        if (state_q == ST_SWEEP) begin
            valid_q[sweep_cnt_q] <= '0;
            dirty_q[sweep_cnt_q] <= '0;
            rr_q[sweep_cnt_q]    <= '0;
        end else if (idle && wr_ena_i) begin
            tag_q[wr_index_i][wr_way_i]   <= wr_tag_i;
            valid_q[wr_index_i][wr_way_i] <= 1'b1;
            dirty_q[wr_index_i][wr_way_i] <= wr_dirty_i | mark_dirty_i;
            if (wr_way_i == rr_q[wr_index_i]) begin
                rr_q[wr_index_i] <= rr_q[wr_index_i] + 1'b1;
            end
        end else if (idle && mark_dirty_i && valid_q[wr_index_i][wr_way_i]) begin
            dirty_q[wr_index_i][wr_way_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q    <= 1'b0;
            hit_q          <= 1'b0;
            hit_way_q      <= '0;
            hit_dirty_q    <= 1'b0;
            victim_way_q   <= '0;
            victim_valid_q <= 1'b0;
            victim_dirty_q <= 1'b0;
            victim_tag_q   <= '0;
        end else begin
            rsp_valid_q <= lookup_acc;
            if (lookup_acc) begin
                hit_q          <= hit_d;
                hit_way_q      <= hit_way_d;
                hit_dirty_q    <= hit_dirty_d;
                victim_way_q   <= victim_way_d;
                victim_valid_q <= victim_valid_d;
                victim_dirty_q <= victim_dirty_d;
                victim_tag_q   <= victim_tag_d;
            end
        end
    end

    assign rsp_valid_o    = rsp_valid_q;
    assign hit_o          = hit_q;
    assign hit_way_o      = hit_way_q;
    assign hit_dirty_o    = hit_dirty_q;
    assign victim_way_o   = victim_way_q;
    assign victim_valid_o = victim_valid_q;
    assign victim_dirty_o = victim_dirty_q;
    assign victim_tag_o   = victim_tag_q;

endmodule

// File: tb/tb_d_cache_tag_array.sv
// Directed bench for d_cache_tag_array: a default 2-way/64-set instance and a
// 4-way/16-set instance for the parameter checks.
module tb_d_cache_tag_array;
    localparam int TAG_W = 52;

    logic clk;
    int   total = 0;
    int   bad   = 0;

    // instance A: WAYS=2, SETS=64
    logic             rst_a, lv_a, rsp_a, hit_a, hd_a, vv_a, vd_a, we_a, wd_a, md_a, fl_a, busy_a;
    logic [5:0]       li_a, wi_a;
    logic [TAG_W-1:0] lt_a, vt_a, wt_a;
    logic             hw_a, vw_a, ww_a;

    // instance B: WAYS=4, SETS=16
    logic             rst_b, lv_b, rsp_b, hit_b, hd_b, vv_b, vd_b, we_b, wd_b, md_b, fl_b, busy_b;
    logic [3:0]       li_b, wi_b;
    logic [TAG_W-1:0] lt_b, vt_b, wt_b;
    logic [1:0]       hw_b, vw_b, ww_b;

    d_cache_tag_array #(.WAYS(2), .SETS(64), .TAG_W(TAG_W)) dut_a (
        .clk(clk), .rst(rst_a),
        .lookup_valid_i(lv_a), .lookup_index_i(li_a), .lookup_tag_i(lt_a),
        .rsp_valid_o(rsp_a), .hit_o(hit_a), .hit_way_o(hw_a), .hit_dirty_o(hd_a),
        .victim_way_o(vw_a), .victim_valid_o(vv_a), .victim_dirty_o(vd_a), .victim_tag_o(vt_a),
        .wr_ena_i(we_a), .wr_index_i(wi_a), .wr_way_i(ww_a), .wr_tag_i(wt_a), .wr_dirty_i(wd_a),
        .mark_dirty_i(md_a), .flush_i(fl_a), .busy_o(busy_a)
    );

    d_cache_tag_array #(.WAYS(4), .SETS(16), .TAG_W(TAG_W)) dut_b (
        .clk(clk), .rst(rst_b),
        .lookup_valid_i(lv_b), .lookup_index_i(li_b), .lookup_tag_i(lt_b),
        .rsp_valid_o(rsp_b), .hit_o(hit_b), .hit_way_o(hw_b), .hit_dirty_o(hd_b),
        .victim_way_o(vw_b), .victim_valid_o(vv_b), .victim_dirty_o(vd_b), .victim_tag_o(vt_b),
        .wr_ena_i(we_b), .wr_index_i(wi_b), .wr_way_i(ww_b), .wr_tag_i(wt_b), .wr_dirty_i(wd_b),
        .mark_dirty_i(md_b), .flush_i(fl_b), .busy_o(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup_a(input logic [5:0] idx, input logic [TAG_W-1:0] tag);
        lv_a = 1'b1; li_a = idx; lt_a = tag;
        step();
        lv_a = 1'b0;
    endtask

    task automatic write_a(input logic [5:0] idx, input logic way, input logic [TAG_W-1:0] tag,
                           input logic dirty);
        we_a = 1'b1; wi_a = idx; ww_a = way; wt_a = tag; wd_a = dirty;
        step();
        we_a = 1'b0;
    endtask

    task automatic lookup_b(input logic [3:0] idx, input logic [TAG_W-1:0] tag);
        lv_b = 1'b1; li_b = idx; lt_b = tag;
        step();
        lv_b = 1'b0;
    endtask

    task automatic write_b(input logic [3:0] idx, input logic [1:0] way, input logic [TAG_W-1:0] tag);
        we_b = 1'b1; wi_b = idx; ww_b = way; wt_b = tag; wd_b = 1'b0;
        step();
        we_b = 1'b0;
    endtask

    // Steps until busy drops; returns the number of edges taken (bounded).
    task automatic count_busy_a(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (busy_a && n < 200);
    endtask

    initial begin
        int n;
        rst_a = 1'b1; lv_a = 0; li_a = 0; lt_a = 0; we_a = 0; wi_a = 0; ww_a = 0; wt_a = 0;
        wd_a = 0; md_a = 0; fl_a = 0;
        rst_b = 1'b1; lv_b = 0; li_b = 0; lt_b = 0; we_b = 0; wi_b = 0; ww_b = 0; wt_b = 0;
        wd_b = 0; md_b = 0; fl_b = 0;

        repeat (3) step();
        chk("rst_busy", busy_a, 1);
        chk("rst_rsp", rsp_a, 0);
        chk("rst_hit", hit_a, 0);
        chk("rst_hit_way", hw_a, 0);
        chk("rst_vic_valid", vv_a, 0);
        chk("rst_vic_tag", vt_a, 0);

        rst_a = 1'b0;
        count_busy_a(n);
        chk("rst_sweep_len", n, 64);

        lookup_a(6'd5, 52'h123);
        chk("first_rsp", rsp_a, 1);
        chk("first_hit", hit_a, 0);
        chk("first_vway", vw_a, 0);
        chk("first_vvalid", vv_a, 0);
        step();
        chk("rsp_pulse", rsp_a, 0);

        // Fill and hit, then mark dirty
        write_a(6'd7, 1'b1, 52'hABC, 1'b0);
        lookup_a(6'd7, 52'hABC);
        chk("fill_hit", hit_a, 1);
        chk("fill_hit_way", hw_a, 1);
        chk("fill_hit_dirty", hd_a, 0);
        md_a = 1'b1; wi_a = 6'd7; ww_a = 1'b1;
        step();
        md_a = 1'b0;
        lookup_a(6'd7, 52'hABC);
        chk("mark_hit_dirty", hd_a, 1);

        // Replacement: both ways valid, round-robin back at way 0
        write_a(6'd3, 1'b0, 52'h10, 1'b1);
        write_a(6'd3, 1'b1, 52'h11, 1'b0);
        lookup_a(6'd3, 52'h12);
        chk("repl_hit", hit_a, 0);
        chk("repl_vway", vw_a, 0);
        chk("repl_vtag", vt_a, 52'h10);
        chk("repl_vdirty", vd_a, 1);
        chk("repl_vvalid", vv_a, 1);
        write_a(6'd3, 1'b0, 52'h12, 1'b0);
        lookup_a(6'd3, 52'h12);
        chk("refill_hit", hit_a, 1);
        chk("refill_hit_way", hw_a, 0);
        chk("refill_vway", vw_a, 1);

        // Read-before-write in the same cycle
        lv_a = 1'b1; li_a = 6'd9; lt_a = 52'h55;
        we_a = 1'b1; wi_a = 6'd9; ww_a = 1'b0; wt_a = 52'h55; wd_a = 1'b0;
        step();
        lv_a = 1'b0; we_a = 1'b0;
        chk("rbw_miss", hit_a, 0);
        lookup_a(6'd9, 52'h55);
        chk("rbw_hit", hit_a, 1);
        chk("rbw_hit_way", hw_a, 0);

        // Back-to-back lookups
        lv_a = 1'b1; li_a = 6'd7; lt_a = 52'hABC;
        step();
        chk("b2b_rsp0", rsp_a, 1);
        chk("b2b_hit_way0", hw_a, 1);
        li_a = 6'd3; lt_a = 52'h11;
        step();
        lv_a = 1'b0;
        chk("b2b_rsp1", rsp_a, 1);
        chk("b2b_hit1", hit_a, 1);
        chk("b2b_hit_way1", hw_a, 1);

        // Fill and mark-dirty together
        we_a = 1'b1; md_a = 1'b1; wi_a = 6'd11; ww_a = 1'b0; wt_a = 52'h77; wd_a = 1'b0;
        step();
        we_a = 1'b0; md_a = 1'b0;
        lookup_a(6'd11, 52'h77);
        chk("wrmark_hit", hit_a, 1);
        chk("wrmark_dirty", hd_a, 1);

        // Flush: lookup during sweep dropped, second flush ignored
        fl_a = 1'b1;
        step();
        fl_a = 1'b0;
        chk("flush_busy", busy_a, 1);
        lv_a = 1'b1; li_a = 6'd7; lt_a = 52'hABC;
        step();
        lv_a = 1'b0;
        n = 1;
        chk("flush_rsp_drop", rsp_a, 0);
        while (busy_a && n < 200) begin
            fl_a = (n == 5);
            step();
            n++;
        end
        fl_a = 1'b0;
        chk("flush_len", n, 64);
        lookup_a(6'd7, 52'hABC);
        chk("post_flush_hit7", hit_a, 0);
        chk("post_flush_vd7", vd_a, 0);
        lookup_a(6'd3, 52'h10);
        chk("post_flush_hit3", hit_a, 0);
        chk("post_flush_vd3", vd_a, 0);
        chk("post_flush_vv3", vv_a, 0);

        // Reset in mid-sweep restarts from set 0
        fl_a = 1'b1;
        step();
        fl_a = 1'b0;
        repeat (10) step();
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        count_busy_a(n);
        chk("rst_mid_sweep_len", n, 64);

        // Instance B: 16-set sweep and 4-way round-robin
        rst_b = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (busy_b && n < 200);
        chk("b_sweep_len", n, 16);
        for (int w = 0; w < 4; w++) write_b(4'd2, 2'(w), 52'h200 + 52'(w));
        lookup_b(4'd2, 52'h2FF);
        chk("b_vway0", vw_b, 0);
        chk("b_vvalid0", vv_b, 1);
        chk("b_vtag0", vt_b, 52'h200);
        for (int w = 0; w < 3; w++) begin
            write_b(4'd2, 2'(w), 52'h300 + 52'(w));
            lookup_b(4'd2, 52'h2FF);
            chk("b_vway_rot", vw_b, 64'(w + 1));
            chk("b_vvalid_rot", vv_b, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
